// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared helpers for the pipelined ripple-carry adder
package rca_pkg;

    // Bits resolved per pipeline stage.
    function automatic int rca_chunk(input int width, input int stages);
        return (stages < 1) ? 1 : width / stages;
    endfunction

    // Legal configuration: at least one stage and equal, non-empty slices.
    function automatic bit rca_cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

    // Start of stage k's region in the flattened operand-B link. Stage k still
    // needs width - k*chunk bits of B, so the regions shrink by one chunk per stage.
    function automatic int rca_y_off(input int width, input int chunk, input int k);
        return k * width - (chunk * (k * (k - 1))) / 2;
    endfunction

endpackage

// File: rtl/rca_slice.sv
// rtl/rca_slice.sv - combinational CHUNK-bit ripple-carry slice
module rca_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_msb_in
);

    // Full-adder chain from LSB to MSB; also expose the carry entering the MSB.
    always_comb begin
        logic carry;
        carry    = ci;
        sum      = '0;
        c_msb_in = ci;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb_in = carry;
            end
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - pipelined ripple-carry add/sub with valid/ready; RCA_OVERFLOW_FLAG_EN adds ovf
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef RCA_OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK   = rca_chunk(WIDTH, STAGES);
    localparam bit CFG_OK  = rca_cfg_ok(WIDTH, STAGES);
    localparam int YLINK_W = rca_y_off(WIDTH, CHUNK, STAGES);

    if (!CFG_OK) begin : g_bad_cfg
        $fatal(1, "pipelined_rca: WIDTH must be a positive multiple of STAGES");
    end

    logic                       stall;
    logic                       advance;
    // Index k is the input of stage k; index STAGES is the pipeline output.
    logic [STAGES:0][WIDTH-1:0] x_chain;
    logic [STAGES:0]            c_chain;
    logic [STAGES:0]            v_chain;
    // Right-justified B bits still to be added, one shrinking region per stage.
    logic [YLINK_W-1:0]         y_link;

    assign stall     = v_chain[STAGES] & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = ~stall;

    assign x_chain[0]         = a;
    assign c_chain[0]         = cin ^ sub;
    assign v_chain[0]         = in_valid;
    assign y_link[WIDTH-1:0]  = b ^ {WIDTH{sub}};

    assign out_valid = v_chain[STAGES];
    assign s         = x_chain[STAGES];
    assign cout      = c_chain[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int YOFF = rca_y_off(WIDTH, CHUNK, k);
        localparam int YIN  = WIDTH - k * CHUNK;

        logic [CHUNK-1:0] sum_w;
        logic             co_w;
        logic [WIDTH-1:0] x_d;
        logic [WIDTH-1:0] x_q;
        logic             c_d;
        logic             c_q;
        logic             v_d;
        logic             v_q;

`ifdef RCA_OVERFLOW_FLAG_EN
        if (k == STAGES - 1) begin : g_slice_ovf
            logic msb_w;
            logic m_d;
            logic m_q;

            rca_slice #(.CHUNK(CHUNK)) u_slice (
                .x        (x_chain[k][k*CHUNK +: CHUNK]),
                .y        (y_link[YOFF +: CHUNK]),
                .ci       (c_chain[k]),
                .sum      (sum_w),
                .co       (co_w),
                .c_msb_in (msb_w)
            );

            always_comb m_d = msb_w;

            // Carry into the MSB travels with the result so ovf holds with s on stall.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    m_q <= 1'b0;
                end else if (advance) begin
                    m_q <= m_d;
                end
            end

            assign ovf = m_q ^ c_q;
        end else begin : g_slice
            logic msb_unused;

            rca_slice #(.CHUNK(CHUNK)) u_slice (
                .x        (x_chain[k][k*CHUNK +: CHUNK]),
                .y        (y_link[YOFF +: CHUNK]),
                .ci       (c_chain[k]),
                .sum      (sum_w),
                .co       (co_w),
                .c_msb_in (msb_unused)
            );
        end
`else
        logic msb_unused;

        rca_slice #(.CHUNK(CHUNK)) u_slice (
            .x        (x_chain[k][k*CHUNK +: CHUNK]),
            .y        (y_link[YOFF +: CHUNK]),
            .ci       (c_chain[k]),
            .sum      (sum_w),
            .co       (co_w),
            .c_msb_in (msb_unused)
        );
`endif

        // Splice this slice's sum into the travelling word; lower sums and upper A bits pass through.
        always_comb begin
            x_d                   = x_chain[k];
            x_d[k*CHUNK +: CHUNK] = sum_w;
            c_d                   = co_w;
            v_d                   = v_chain[k];
        end

        // Stage register: whole pipeline advances together unless the output is stalled.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                x_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance) begin
                x_q <= x_d;
                c_q <= c_d;
                v_q <= v_d;
            end
        end

        assign x_chain[k+1] = x_q;
        assign c_chain[k+1] = c_q;
        assign v_chain[k+1] = v_q;

        if (k < STAGES - 1) begin : g_yreg
            logic [YIN-CHUNK-1:0] y_d;
            logic [YIN-CHUNK-1:0] y_q;

            always_comb y_d = y_link[YOFF+CHUNK +: YIN-CHUNK];

            // Carry forward only the B bits later stages still need.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    y_q <= '0;
                end else if (advance) begin
                    y_q <= y_d;
                end
            end

            assign y_link[YOFF+YIN +: YIN-CHUNK] = y_q;
        end
    end

endmodule

// File: tb/tb_pipelined_rca.sv
// tb/tb_pipelined_rca.sv - directed self-checking bench for pipelined_rca
module tb_pipelined_rca;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
`ifdef RCA_OVERFLOW_FLAG_EN
    logic        ovf;
    logic        ovf1;
`endif

    logic        in_valid1;
    logic        in_ready1;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        cin1;
    logic        sub1;
    logic        out_valid1;
    logic        out_ready1;
    logic [7:0]  s1;
    logic        cout1;

    int checks;
    int failures;

    pipelined_rca #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef RCA_OVERFLOW_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    pipelined_rca #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .sub       (sub1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .s         (s1),
        .cout      (cout1)
`ifdef RCA_OVERFLOW_FLAG_EN
        ,
        .ovf       (ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                          output logic [15:0] rs, output logic rc, output logic ro, output int lat);
        @(posedge clk); #1;
        out_ready = 1'b1;
        a = ta; b = tb; cin = tc; sub = ts;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = s;
        rc = cout;
`ifdef RCA_OVERFLOW_FLAG_EN
        ro = ovf;
`else
        ro = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (s !== 16'h0000) begin failures++; $display("FAIL reset_s: got %h want 0000", s); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid1: got %b want 0", out_valid1); end
    endtask

    task automatic test_latency();
        logic [15:0] rs; logic rc; logic ro; int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL latency: got %0d want 4", lat); end
        checks++; if (rs !== 16'h0000) begin failures++; $display("FAIL wrap_s: got %h want 0000", rs); end
        checks++; if (rc !== 1'b1) begin failures++; $display("FAIL wrap_cout: got %b want 1", rc); end
    endtask

    task automatic test_subtract();
        logic [15:0] rs; logic rc; logic ro; int lat;
        run_op(16'h1234, 16'h0235, 1'b0, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 16'h0FFF) begin failures++; $display("FAIL sub1_s: got %h want 0fff", rs); end
        checks++; if (rc !== 1'b1) begin failures++; $display("FAIL sub1_cout: got %b want 1", rc); end
        run_op(16'h0000, 16'h0001, 1'b0, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 16'hFFFF) begin failures++; $display("FAIL sub2_s: got %h want ffff", rs); end
        checks++; if (rc !== 1'b0) begin failures++; $display("FAIL sub2_cout: got %b want 0", rc); end
        run_op(16'h0005, 16'h0003, 1'b1, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 16'h0001) begin failures++; $display("FAIL sub3_s: got %h want 0001", rs); end
        checks++; if (rc !== 1'b1) begin failures++; $display("FAIL sub3_cout: got %b want 1", rc); end
    endtask

`ifdef RCA_OVERFLOW_FLAG_EN
    task automatic test_overflow();
        logic [15:0] rs; logic rc; logic ro; int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        checks++; if (rs !== 16'h8000) begin failures++; $display("FAIL ovf1_s: got %h want 8000", rs); end
        checks++; if (ro !== 1'b1) begin failures++; $display("FAIL ovf1_ovf: got %b want 1", ro); end
        checks++; if (rc !== 1'b0) begin failures++; $display("FAIL ovf1_cout: got %b want 0", rc); end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 16'h7FFF) begin failures++; $display("FAIL ovf2_s: got %h want 7fff", rs); end
        checks++; if (ro !== 1'b1) begin failures++; $display("FAIL ovf2_ovf: got %b want 1", ro); end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        checks++; if (ro !== 1'b0) begin failures++; $display("FAIL ovf3_ovf: got %b want 0", ro); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic        vc [8];
        logic        vs [8];
        logic [15:0] es [8];
        logic        ec [8];
        int drv;
        int rcv;
        int cyc;
        int extra;
        va = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1000, 16'h00FF, 16'h0000, 16'h0F0F, 16'h0003};
        vb = '{16'h0002, 16'hFFFF, 16'h8000, 16'h0001, 16'h0F01, 16'h0000, 16'h00F1, 16'h0004};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        es = '{16'h0003, 16'hFFFE, 16'h0001, 16'h0FFF, 16'h1000, 16'h0000, 16'h1001, 16'hFFFF};
        ec = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        drv = 0; rcv = 0; cyc = 0;
        while (rcv < 8 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (drv < 8) begin
                in_valid = 1'b1; a = va[drv]; b = vb[drv]; cin = vc[drv]; sub = vs[drv];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 6 && cyc <= 8) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc%0d: got %b want 0", cyc, in_ready); end
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid cyc%0d: got %b want 1", cyc, out_valid); end
            end
            if (out_valid && rcv < 8) begin
                checks++; if (s !== es[rcv]) begin failures++; $display("FAIL stream_s[%0d] cyc%0d: got %h want %h", rcv, cyc, s, es[rcv]); end
                checks++; if (cout !== ec[rcv]) begin failures++; $display("FAIL stream_cout[%0d] cyc%0d: got %b want %b", rcv, cyc, cout, ec[rcv]); end
            end
            if (out_valid && out_ready) rcv++;
            if (in_valid && in_ready) drv++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (rcv !== 8) begin failures++; $display("FAIL stream_count: got %0d want 8", rcv); end
        checks++; if (drv !== 8) begin failures++; $display("FAIL stream_accepted: got %0d want 8", drv); end
        checks++; if (cyc !== 15) begin failures++; $display("FAIL stream_rate: got %0d cycles want 15", cyc); end
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL stream_duplicate: got %0d extra results want 0", extra); end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] rs; logic rc; logic ro; int lat;
        int stale;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'h0010 + 16'(i); b = 16'h0001; cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        stale = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin failures++; $display("FAIL midreset_stale: got %0d results want 0", stale); end
        run_op(16'h0100, 16'h0011, 1'b0, 1'b0, rs, rc, ro, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL midreset_latency: got %0d want 4", lat); end
        checks++; if (rs !== 16'h0111) begin failures++; $display("FAIL midreset_s: got %h want 0111", rs); end
        checks++; if (rc !== 1'b0) begin failures++; $display("FAIL midreset_cout: got %b want 0", rc); end
    endtask

    task automatic test_single_stage();
        @(posedge clk); #1;
        out_ready1 = 1'b1;
        in_valid1 = 1'b1; a1 = 8'hC3; b1 = 8'h3C; cin1 = 1'b1; sub1 = 1'b0;
        #1;
        checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL s1_in_ready: got %b want 1", in_ready1); end
        @(posedge clk); #1;
        in_valid1 = 1'b1; a1 = 8'h80; b1 = 8'h01; cin1 = 1'b0; sub1 = 1'b1;
        checks++; if (out_valid1 !== 1'b1) begin failures++; $display("FAIL s1_latency: got out_valid %b want 1", out_valid1); end
        checks++; if (s1 !== 8'h00) begin failures++; $display("FAIL s1_s: got %h want 00", s1); end
        checks++; if (cout1 !== 1'b1) begin failures++; $display("FAIL s1_cout: got %b want 1", cout1); end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        checks++; if (s1 !== 8'h7F) begin failures++; $display("FAIL s1_sub_s: got %h want 7f", s1); end
        checks++; if (cout1 !== 1'b1) begin failures++; $display("FAIL s1_sub_cout: got %b want 1", cout1); end
        @(posedge clk); #1;
        checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL s1_drain: got out_valid %b want 0", out_valid1); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_latency();
        test_subtract();
`ifdef RCA_OVERFLOW_FLAG_EN
        test_overflow();
`endif
        test_back_to_back();
        test_reset_midstream();
        test_single_stage();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
